// File: rtl/out_disp_pkg.sv
// Shared types and constants for the output display register and its
// double-dabble converter.
package out_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  localparam int unsigned ITERS   = 8;
  localparam int unsigned CONV_W  = 20;
  localparam logic [7:0]  SAT_VAL = 8'h99;

endpackage

// File: rtl/out_disp_reg_bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/out_disp_reg.sv
// Display value register feeding the seven-segment controller.
// Define OUT_DISP_BCD_EN for decimal (double-dabble, saturating) mode; otherwise a raw binary pass-through register.
module out_disp_reg
  import out_disp_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       clr,
  output logic [7:0] dout,
  output logic       dout_upd,
  output logic       ovf
);

`ifdef OUT_DISP_BCD_EN

  localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CONV_W-1:0]   conv;
  logic [CONV_W-1:0]   conv_adj;
  logic [2:0]          cnt;

  // conv = {hundreds, tens, ones, binary}; only the BCD digits are corrected.
  bcd_adj3 u_adj_hund (.din(conv[19:16]), .dout(conv_adj[19:16]));
  bcd_adj3 u_adj_tens (.din(conv[15:12]), .dout(conv_adj[15:12]));
  bcd_adj3 u_adj_ones (.din(conv[11:8]),  .dout(conv_adj[11:8]));
  assign conv_adj[7:0] = conv[7:0];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV:    if (cnt == LAST_ITER) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      conv     <= '0;
      cnt      <= '0;
      dout     <= RESET_VAL;
      ovf      <= 1'b0;
      dout_upd <= 1'b0;
    end else begin
      dout_upd <= 1'b0;
      if (clr) begin
        conv     <= '0;
        cnt      <= '0;
        dout     <= RESET_VAL;
        ovf      <= 1'b0;
        dout_upd <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              conv <= CONV_W'(in_data);
              cnt  <= '0;
            end
          end
          CONV: begin
            conv <= conv_adj << 1;
            cnt  <= cnt + 3'd1;
          end
          LOAD: begin
            dout_upd <= 1'b1;
            if (conv[19:16] == 4'd0) begin
              dout <= conv[15:8];
              ovf  <= 1'b0;
            end else begin
              dout <= SAT_VAL;
              ovf  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`else

  assign in_ready = 1'b1;
  assign ovf      = 1'b0;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      dout     <= RESET_VAL;
      dout_upd <= 1'b0;
    end else begin
      dout_upd <= 1'b0;
      if (clr) begin
        dout     <= RESET_VAL;
        dout_upd <= 1'b1;
      end else if (in_valid) begin
        dout     <= in_data;
        dout_upd <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: doc/out_disp_reg.md
OUT_DISP_REG -- requirements
Module: out_disp_reg

Interface
REQ-001 Parameter RESET_VAL, default 8'h00; dout value after reset or clear.
REQ-002 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-003 RESETN  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  write request from the CPU output port.
REQ-005 in_ready  output  1  block can accept a write this cycle.
REQ-006 in_data  input  8  binary value to display.
REQ-007 clr  input  1  synchronous clear of the display value.
REQ-008 dout  output  8  two-nibble value for the seven-segment controller's din; [7:4] is the left digit.
REQ-009 dout_upd  output  1  one-cycle pulse in the cycle dout takes a new value.
REQ-010 ovf  output  1  last displayed value saturated (BCD mode only).

Function
REQ-011 A write SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_data is captured on that edge.
REQ-012 The FSM SHALL have exactly three states: IDLE, CONV, LOAD. IDLE goes to CONV on accept. CONV goes to LOAD after its 8th iteration. LOAD goes to IDLE unconditionally.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 CONV SHALL run one double-dabble iteration per cycle, 8 iterations total, on a 20-bit register: 12-bit BCD result plus 8-bit binary.
REQ-015 Each iteration SHALL add 3 to every BCD digit that is >= 5, then shift the whole register left by one.
REQ-016 In LOAD, hundreds == 0: dout <= {tens, ones} and ovf <= 0.
REQ-017 In LOAD, hundreds != 0: dout <= 8'h99 and ovf <= 1.
REQ-018 dout SHALL change only on the LOAD edge, and dout_upd SHALL be 1 for exactly the cycle following that edge.
REQ-019 Latency SHALL be 10 edges from accept to dout update. in_ready SHALL return to 1 in the same cycle dout_upd is 1. Maximum throughput is one write per 10 cycles.
REQ-020 clr SHALL take priority over everything else: abort any conversion, go to IDLE, set dout <= RESET_VAL and ovf <= 0, and pulse dout_upd.
REQ-021 If clr and an accepting in_valid occur in the same cycle, the write SHALL be discarded.
REQ-022 in_valid while in_ready is 0 SHALL be ignored, with no buffering; the writer holds in_valid until accepted.
REQ-023 dout SHALL hold its value indefinitely between updates.

Reset
REQ-024 RESETN low SHALL immediately give: state IDLE, dout = RESET_VAL, ovf = 0, dout_upd = 0, conversion register and iteration counter = 0.
REQ-025 Reset asserted mid-conversion SHALL abandon the conversion, with no dout_upd pulse.
REQ-026 in_ready SHALL be 1 in the first cycle after RESETN deasserts.

Configuration
REQ-027 Macro OUT_DISP_BCD_EN defined: decimal mode per REQ-012..REQ-019.
REQ-028 Macro OUT_DISP_BCD_EN undefined:
- CONV and LOAD states are omitted and in_ready is constantly 1.
- An accepted write SHALL set dout <= in_data on the accept edge, with dout_upd in the following cycle (latency 1; back-to-back writes every cycle).
- ovf SHALL be constant 0.
- clr behaviour is unchanged.

Structure
REQ-029 Shared package out_disp_pkg SHALL hold:
- the state enum (IDLE, CONV, LOAD);
- constant ITERS = 8;
- constant SAT_VAL = 8'h99;
- the conversion register width constant (20).
REQ-030 The per-digit conditional add-3 SHALL be a combinational sub-module named bcd_adj3, instantiated three times.

Verification
REQ-031 Bench SHALL cover each scenario below, in both macro settings where applicable:
- Reset, then BCD mode, write 8'd42 -> in_ready low for 9 cycles; dout = 8'h42 with one dout_upd pulse 10 edges after accept; ovf = 0.
- BCD mode, write 8'd255 -> dout = 8'h99, ovf = 1; then write 8'd7 -> dout = 8'h07, ovf = 0.
- BCD mode, write 8'd99 then write 8'd100 on consecutive ready windows -> dout 8'h99 with ovf 0, then 8'h99 with ovf 1; in_valid held during busy is accepted only when in_ready returns.
- BCD mode, clr 4 cycles after accepting 8'd50 -> dout = RESET_VAL, no 8'h50 update ever appears, in_ready high the next cycle; clr coincident with a write -> write dropped.
- RESETN pulsed low mid-conversion -> outputs immediately at reset values, no dout_upd; next write 8'd0 -> dout 8'h00 after 10 edges.
- Macro undefined, writes 8'hA5, 8'h3C on consecutive cycles -> dout 8'hA5 then 8'h3C, each 1 cycle after accept, dout_upd high both cycles, ovf constant 0.
